// File: rtl/caxi4dma_pkg.sv
// Shared constants for the AXI4 DMA interrupt path: flag bit positions and
// the field widths that make up one queued interrupt event.
package caxi4dma_pkg;

  // Bit positions inside the 4-bit flag vector {invDscrptr, rdErr, wrErr, opDone}
  localparam int FLAG_OPDONE     = 0;
  localparam int FLAG_WRERR      = 1;
  localparam int FLAG_RDERR      = 2;
  localparam int FLAG_INVDSCRPTR = 3;

  // Field widths of a queued event
  localparam int FLAG_W = 4;
  localparam int STR_W  = 1;
  localparam int ADDR_W = 32;

  // Packed entry layout, MSB to LSB: {flags, dscrptrNum, strDscrptr, addr}
  function automatic int entry_width(input int num_w);
    return FLAG_W + num_w + STR_W + ADDR_W;
  endfunction

endpackage

// File: rtl/caxi4dma_int_evt_fifo_mem.sv
// Register array backing the interrupt event queue: one synchronous write
// port and one asynchronous read port so the head entry falls through.
module caxi4dma_int_evt_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 39
) (
  input  logic                     CLOCK,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the incoming entry at the write pointer.
  // NOTE: storage has no reset; validity is tracked by the occupancy count,
  // so clearing the array would only cost a reset tree for nothing.
  always_ff @(posedge CLOCK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/caxi4dma_int_event_queue.sv
// Interrupt event queue: captures single-cycle events from the status mux
// into a small FWFT queue, presents the head entry to the register block,
// and drives a registered, maskable interrupt request.
module caxi4dma_int_event_queue
  import caxi4dma_pkg::*;
#(
  parameter int NUM_DSCRPTR_WIDTH = 2,
  parameter int DEPTH             = 4,
  parameter int CNT_WIDTH         = $clog2(DEPTH + 1)
) (
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic                         evtValid,
  input  logic                         evtOpDone,
  input  logic                         evtWrErr,
  input  logic                         evtRdErr,
  input  logic                         evtInvDscrptr,
  input  logic [NUM_DSCRPTR_WIDTH-1:0] evtDscrptrNum,
  input  logic                         evtStrDscrptr,
  input  logic [31:0]                  evtAddr,
  input  logic [3:0]                   intMask,
  input  logic                         popStrobe,
  input  logic                         clrAll,
  output logic                         headValid,
  output logic [3:0]                   headFlags,
  output logic [NUM_DSCRPTR_WIDTH-1:0] headDscrptrNum,
  output logic                         headStrDscrptr,
  output logic [31:0]                  headAddr,
  output logic [CNT_WIDTH-1:0]         entryCount,
  output logic                         overflow,
  output logic                         irq
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = entry_width(NUM_DSCRPTR_WIDTH);

  logic [PTR_W-1:0]     wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]     rd_ptr, rd_ptr_nxt;
  logic [CNT_WIDTH-1:0] count_q, count_nxt;
  logic                 overflow_q, overflow_nxt;
  logic                 irq_q, irq_nxt;
  logic                 full, empty;
  logic                 do_push, do_pop, drop;
  logic [FLAG_W-1:0]    evt_flags;
  logic [ENTRY_W-1:0]   wdata, rdata;

  assign full  = (count_q == CNT_WIDTH'(DEPTH));
  assign empty = (count_q == '0);

  // Flush wins over everything; a pop on a full queue frees the slot the
  // concurrent push needs, and a pop on an empty queue has nothing to remove.
  assign do_pop  = popStrobe && !empty && !clrAll;
  assign do_push = evtValid && !clrAll && (!full || do_pop);
  assign drop    = evtValid && !clrAll && full && !do_pop;

  // Assemble the flag vector using the shared bit positions.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    evt_flags                  = '0;
    evt_flags[FLAG_OPDONE]     = evtOpDone;
    evt_flags[FLAG_WRERR]      = evtWrErr;
    evt_flags[FLAG_RDERR]      = evtRdErr;
    evt_flags[FLAG_INVDSCRPTR] = evtInvDscrptr;
  end

  assign wdata = {evt_flags, evtDscrptrNum, evtStrDscrptr, evtAddr};

  caxi4dma_int_evt_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .CLOCK (CLOCK),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Head outputs fall through from the read pointer and read as zero when empty.
  always_comb begin
    headValid      = !empty;
    headFlags      = '0;
    headDscrptrNum = '0;
    headStrDscrptr = 1'b0;
    headAddr       = '0;
    if (!empty) begin
      headFlags      = rdata[ENTRY_W-1 -: FLAG_W];
      headDscrptrNum = rdata[ADDR_W+STR_W +: NUM_DSCRPTR_WIDTH];
      headStrDscrptr = rdata[ADDR_W];
      headAddr       = rdata[ADDR_W-1:0];
    end
  end

  // Next-state for pointers, occupancy, sticky overflow and the interrupt.
  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count_q;
    overflow_nxt = overflow_q;
    if (clrAll) begin
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      count_nxt    = '0;
      overflow_nxt = 1'b0;
    end else begin
      if (do_push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_nxt = count_q + CNT_WIDTH'(1);
        2'b01:   count_nxt = count_q - CNT_WIDTH'(1);
        default: count_nxt = count_q;
      endcase
      if (drop) overflow_nxt = 1'b1;
    end
    // Interrupt follows the presented head and mask one edge later; a flush
    // clears it on the same edge as the queue.
    irq_nxt = !clrAll && headValid && |(headFlags & intMask);
  end

  // State register with asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count_q    <= count_nxt;
      overflow_q <= overflow_nxt;
      irq_q      <= irq_nxt;
    end
  end

  assign entryCount = count_q;
  assign overflow   = overflow_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_caxi4dma_int_event_queue.sv
// Bench for the interrupt event queue: directed stimulus pushes expected
// entries into a scoreboard queue; a monitor compares the head on each pop.
module tb_caxi4dma_int_event_queue;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        evtValid, evtOpDone, evtWrErr, evtRdErr, evtInvDscrptr;
  logic [1:0]  evtDscrptrNum;
  logic        evtStrDscrptr;
  logic [31:0] evtAddr;
  logic [3:0]  intMask;
  logic        popStrobe, clrAll;
  logic        headValid;
  logic [3:0]  headFlags;
  logic [1:0]  headDscrptrNum;
  logic        headStrDscrptr;
  logic [31:0] headAddr;
  logic [2:0]  entryCount;
  logic        overflow, irq;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0]  flags;
    logic [1:0]  num;
    logic        str;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];

  always #5 CLOCK = ~CLOCK;

  caxi4dma_int_event_queue #(
    .NUM_DSCRPTR_WIDTH (2),
    .DEPTH             (4),
    .CNT_WIDTH         (3)
  ) dut (
    .CLOCK          (CLOCK),
    .RESET          (RESET),
    .evtValid       (evtValid),
    .evtOpDone      (evtOpDone),
    .evtWrErr       (evtWrErr),
    .evtRdErr       (evtRdErr),
    .evtInvDscrptr  (evtInvDscrptr),
    .evtDscrptrNum  (evtDscrptrNum),
    .evtStrDscrptr  (evtStrDscrptr),
    .evtAddr        (evtAddr),
    .intMask        (intMask),
    .popStrobe      (popStrobe),
    .clrAll         (clrAll),
    .headValid      (headValid),
    .headFlags      (headFlags),
    .headDscrptrNum (headDscrptrNum),
    .headStrDscrptr (headStrDscrptr),
    .headAddr       (headAddr),
    .entryCount     (entryCount),
    .overflow       (overflow),
    .irq            (irq)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_evt(input logic [3:0] f, input logic [1:0] n, input logic s,
                         input logic [31:0] a);
    evtOpDone     = f[0];
    evtWrErr      = f[1];
    evtRdErr      = f[2];
    evtInvDscrptr = f[3];
    evtDscrptrNum = n;
    evtStrDscrptr = s;
    evtAddr       = a;
  endtask

  task automatic push(input logic [3:0] f, input logic [1:0] n, input logic s,
                      input logic [31:0] a, input bit accept);
    set_evt(f, n, s, a);
    evtValid = 1'b1;
    if (accept) exp_q.push_back(exp_t'{flags: f, num: n, str: s, addr: a});
    step();
    evtValid = 1'b0;
  endtask

  task automatic pop();
    popStrobe = 1'b1;
    step();
    popStrobe = 1'b0;
  endtask

  // Monitor: whenever the register block pops a presented head, compare it
  // against the oldest expected entry.
  always @(negedge CLOCK) begin : monitor
    exp_t e;
    if (!RESET && popStrobe && headValid && !clrAll) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected_entry", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("head_flags", 64'(headFlags),      64'(e.flags));
        check("head_num",   64'(headDscrptrNum), 64'(e.num));
        check("head_str",   64'(headStrDscrptr), 64'(e.str));
        check("head_addr",  64'(headAddr),       64'(e.addr));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    RESET = 1'b1;
    evtValid = 1'b0;
    popStrobe = 1'b0;
    clrAll = 1'b0;
    intMask = 4'b0000;
    set_evt(4'b0000, 2'd0, 1'b0, 32'h0);
    step();
    step();
    RESET = 1'b0;
    step();

    // Reset state
    check("rst_headValid", 64'(headValid),  64'd0);
    check("rst_count",     64'(entryCount), 64'd0);
    check("rst_overflow",  64'(overflow),   64'd0);
    check("rst_irq",       64'(irq),        64'd0);
    check("rst_headFlags", 64'(headFlags),  64'd0);
    check("rst_headAddr",  64'(headAddr),   64'd0);

    // Single opDone event, irq one cycle after the head appears
    intMask = 4'b0001;
    push(4'b0001, 2'd2, 1'b0, 32'h1000_0040, 1'b1);
    check("t1_headValid", 64'(headValid),      64'd1);
    check("t1_headAddr",  64'(headAddr),       64'h1000_0040);
    check("t1_headNum",   64'(headDscrptrNum), 64'd2);
    check("t1_irq_lag",   64'(irq),            64'd0);
    step();
    check("t1_irq",       64'(irq),            64'd1);
    pop();
    check("t1_pop_headValid", 64'(headValid),  64'd0);
    step();
    check("t1_pop_irq",   64'(irq),            64'd0);

    // Pop on empty is ignored
    pop();
    check("empty_pop_count",    64'(entryCount), 64'd0);
    check("empty_pop_overflow", 64'(overflow),   64'd0);

    // Push+pop on empty: push accepted, pop ignored; all-zero flags stored
    set_evt(4'b0000, 2'd1, 1'b1, 32'h1500_0000);
    evtValid = 1'b1;
    popStrobe = 1'b1;
    exp_q.push_back(exp_t'{flags: 4'b0000, num: 2'd1, str: 1'b1, addr: 32'h1500_0000});
    step();
    evtValid = 1'b0;
    popStrobe = 1'b0;
    check("empty_pushpop_count", 64'(entryCount), 64'd1);
    pop();
    check("empty_pushpop_drain", 64'(entryCount), 64'd0);

    // Five events into four entries: fifth dropped, overflow sticky
    for (int i = 1; i <= 5; i++) begin
      push(4'b0001, 2'(i), 1'b0, 32'h2000_0000 + 32'(i), i <= 4);
    end
    check("t2_count_full", 64'(entryCount), 64'd4);
    check("t2_overflow",   64'(overflow),   64'd1);
    repeat (4) pop();
    check("t2_count_drained", 64'(entryCount), 64'd0);
    check("t2_overflow_sticky", 64'(overflow), 64'd1);
    check("t2_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    clrAll = 1'b1;
    step();
    clrAll = 1'b0;
    check("t2_clr_overflow", 64'(overflow), 64'd0);

    // Full queue with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      push(4'b0100, 2'(i), 1'b1, 32'h3000_0000 + 32'(i), 1'b1);
    end
    set_evt(4'b1000, 2'd3, 1'b0, 32'h3000_00BB);
    evtValid = 1'b1;
    popStrobe = 1'b1;
    exp_q.push_back(exp_t'{flags: 4'b1000, num: 2'd3, str: 1'b0, addr: 32'h3000_00BB});
    step();
    evtValid = 1'b0;
    popStrobe = 1'b0;
    check("t3_count", 64'(entryCount), 64'd4);
    check("t3_overflow", 64'(overflow), 64'd0);
    repeat (3) pop();
    check("t3_count_one", 64'(entryCount), 64'd1);
    check("t3_new_head",  64'(headAddr),   64'h3000_00BB);
    pop();
    check("t3_count_zero", 64'(entryCount), 64'd0);

    // Masked wrErr event, then unmask
    intMask = 4'b0001;
    push(4'b0010, 2'd1, 1'b0, 32'h4000_0000, 1'b1);
    step();
    check("t4_headValid", 64'(headValid), 64'd1);
    check("t4_irq_masked", 64'(irq), 64'd0);
    intMask = 4'b0010;
    step();
    check("t4_irq_unmasked", 64'(irq), 64'd1);
    pop();
    step();

    // Flush with concurrent event: nothing stored, overflow cleared
    intMask = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      push(4'b0001, 2'(i), 1'b0, 32'h5000_0000 + 32'(i), i < 4);
    end
    pop();
    check("t5_count3",   64'(entryCount), 64'd3);
    check("t5_overflow", 64'(overflow),   64'd1);
    check("t5_irq",      64'(irq),        64'd1);
    set_evt(4'b0001, 2'd0, 1'b0, 32'h5000_00FF);
    evtValid = 1'b1;
    clrAll = 1'b1;
    step();
    evtValid = 1'b0;
    clrAll = 1'b0;
    exp_q.delete();
    check("t5_clr_count",     64'(entryCount), 64'd0);
    check("t5_clr_overflow",  64'(overflow),   64'd0);
    check("t5_clr_headValid", 64'(headValid),  64'd0);
    check("t5_clr_irq",       64'(irq),        64'd0);
    step();
    check("t5_not_stored",    64'(entryCount), 64'd0);

    // Asynchronous reset mid-stream, then wrap over ten push/pop pairs
    push(4'b0001, 2'd1, 1'b0, 32'h6000_0001, 1'b1);
    push(4'b0001, 2'd2, 1'b0, 32'h6000_0002, 1'b1);
    step();
    check("t6_count2", 64'(entryCount), 64'd2);
    check("t6_irq_pre", 64'(irq), 64'd1);
    #2;
    RESET = 1'b1;
    #1;
    check("t6_async_irq",       64'(irq),        64'd0);
    check("t6_async_headValid", 64'(headValid),  64'd0);
    check("t6_async_count",     64'(entryCount), 64'd0);
    exp_q.delete();
    step();
    RESET = 1'b0;
    step();
    check("t6_post_count", 64'(entryCount), 64'd0);
    for (int i = 0; i < 10; i++) begin
      push(4'(i), 2'(i), 1'(i), 32'h7000_0000 + 32'(i), 1'b1);
      pop();
    end
    check("t6_wrap_count", 64'(entryCount), 64'd0);
    check("t6_wrap_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
